// File: rtl/emin_dp_accum_pkg.sv
// formant_pkg: shared types and defaults for the Emin DP accumulation path
package formant_pkg;
    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;
    localparam int BIT_WIDTH_DEF = 32;
    localparam int I_DEF = 160;
    localparam int K_MAX_DEF = 4;
    localparam int BRAM_LATENCY = 2;
    localparam logic [BIT_WIDTH_DEF-1:0] COST_INF = '1;
endpackage

// File: rtl/emin_dp_accum_sat_add.sv
// sat_add: unsigned saturating adder where an all-ones operand acts as INF
module sat_add #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);
    logic [W:0] s;
    assign s = {1'b0, a} + {1'b0, b};
    assign y = (&a || &b || s[W]) ? '1 : s[W-1:0];
endmodule

// File: rtl/emin_dp_accum.sv
// emin_dp_accum: adds each Emin(j,i) to F(k-1,j-1), tracks min/argmin over j, writes F(k,i)
module emin_dp_accum
    import formant_pkg::*;
#(
    parameter int BIT_WIDTH = BIT_WIDTH_DEF,
    parameter int I = I_DEF,
    parameter int K_MAX = K_MAX_DEF,
    localparam int IW = $clog2(I),
    localparam int KW = $clog2(K_MAX)
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 start_in,
    input  logic [IW-1:0]        i_in,
    input  logic [KW-1:0]        k_in,
    input  logic                 emin_valid_in,
    input  logic [IW-1:0]        j_in,
    input  logic [BIT_WIDTH-1:0] emin_in,
    output logic [IW-1:0]        f_req,
    input  logic [BIT_WIDTH-1:0] f_resp,
    output logic                 wr_en,
    output logic [IW-1:0]        wr_addr,
    output logic [BIT_WIDTH-1:0] wr_cost,
    output logic [IW-1:0]        wr_bp,
    output logic                 busy,
    output logic                 err
);
    localparam logic [BIT_WIDTH-1:0] INF = '1;
    state_t state;
    logic [IW-1:0] i_q, exp_j, j1, j2, j3, bp_q;
    logic [KW-1:0] k_q;
    logic [BIT_WIDTH-1:0] e1, e2, c3, min_q, sum, cost2, e_clamp;
    logic v1, v2, v3, beat, pipe_empty;
    assign beat = emin_valid_in && state == ACCUM;
    assign pipe_empty = !(v1 || v2 || v3);
    assign e_clamp = emin_in[BIT_WIDTH-1] ? '0 : emin_in;
    assign f_req = (rst_in || j_in == '0) ? '0 : j_in - IW'(1);
    assign busy = state != IDLE;
    // j==0 has no predecessor cost; layer 0 only allows a segment starting at 0
    assign cost2 = (j2 == '0) ? ((k_q == '0) ? e2 : INF) : ((k_q == '0) ? INF : sum);
    sat_add #(.W(BIT_WIDTH)) u_add (.a(f_resp), .b(e2), .y(sum));
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= IDLE;
            i_q <= '0;
            k_q <= '0;
            exp_j <= '0;
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
            e1 <= '0;
            e2 <= '0;
            c3 <= '0;
            j1 <= '0;
            j2 <= '0;
            j3 <= '0;
            min_q <= INF;
            bp_q <= '0;
            wr_en <= 1'b0;
            wr_addr <= '0;
            wr_cost <= '0;
            wr_bp <= '0;
            err <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            v1 <= beat;
            v2 <= v1;
            v3 <= v2;
            e1 <= e_clamp;
            j1 <= j_in;
            e2 <= e1;
            j2 <= j1;
            c3 <= cost2;
            j3 <= j2;
            if (v3 && c3 < min_q) begin
                min_q <= c3;
                bp_q <= j3;
            end
            if ((emin_valid_in && state != ACCUM) || (start_in && state != IDLE) || (beat && j_in != exp_j))
                err <= 1'b1;
            if (state == IDLE && start_in) begin
                state <= ACCUM;
                i_q <= i_in;
                k_q <= k_in;
                exp_j <= '0;
                min_q <= INF;
                bp_q <= '0;
            end
            if (beat) begin
                exp_j <= exp_j + IW'(1);
                if (j_in == i_q) state <= DRAIN;
            end
            if (state == DRAIN && pipe_empty) begin
                state <= IDLE;
                wr_en <= 1'b1;
                wr_addr <= i_q;
                wr_cost <= min_q;
                wr_bp <= bp_q;
            end
        end
    end
endmodule

// File: tb/tb_emin_dp_accum.sv
// tb_emin_dp_accum: directed vectors with hand-computed results for emin_dp_accum
module tb_emin_dp_accum;
    logic clk_in = 1'b0, rst_in = 1'b1, start_in = 1'b0, emin_valid_in = 1'b0;
    logic [7:0] i_in = '0, j_in = '0, f_req, wr_addr, wr_bp;
    logic [1:0] k_in = '0;
    logic [31:0] emin_in = '0, f_resp, wr_cost, r1 = '0, r2 = '0;
    logic wr_en, busy, err;
    logic [31:0] mem [0:159];
    logic [31:0] em [0:7];
    int checks = 0, fails = 0;

    emin_dp_accum dut (
        .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .i_in(i_in), .k_in(k_in),
        .emin_valid_in(emin_valid_in), .j_in(j_in), .emin_in(emin_in), .f_req(f_req),
        .f_resp(f_resp), .wr_en(wr_en), .wr_addr(wr_addr), .wr_cost(wr_cost), .wr_bp(wr_bp),
        .busy(busy), .err(err)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) begin
        r1 <= mem[f_req];
        r2 <= r1;
    end
    assign f_resp = r2;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic send(input int j, input logic [31:0] e);
        emin_valid_in = 1'b1;
        j_in = 8'(j);
        emin_in = e;
        tick();
        emin_valid_in = 1'b0;
        j_in = '0;
    endtask

    task automatic begin_pass(input int ni, input int nk);
        start_in = 1'b1;
        i_in = 8'(ni);
        k_in = 2'(nk);
        tick();
        start_in = 1'b0;
    endtask

    task automatic wait_wr(input string tag, input logic [31:0] xc, input int xbp, input int xaddr);
        int n = 0;
        while (!wr_en && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'(4));
        chk({tag, "_cost"}, 64'(wr_cost), 64'(xc));
        chk({tag, "_bp"}, 64'(wr_bp), 64'(xbp));
        chk({tag, "_addr"}, 64'(wr_addr), 64'(xaddr));
        chk({tag, "_idle"}, 64'(busy), 64'(0));
    endtask

    task automatic run(input int ni, input int nk, input int gap, input logic [31:0] xc, input int xbp, input string tag);
        begin_pass(ni, nk);
        chk({tag, "_busy"}, 64'(busy), 64'(1));
        for (int j = 0; j <= ni; j++) begin
            for (int g = 0; g < gap; g++) tick();
            send(j, em[j]);
        end
        wait_wr(tag, xc, xbp, ni);
    endtask

    task automatic reset_dut();
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
    endtask

    initial begin
        for (int a = 0; a < 160; a++) mem[a] = '0;
        for (int a = 0; a < 8; a++) em[a] = '0;
        tick();
        tick();
        chk("rst_wr_en", 64'(wr_en), 64'(0));
        chk("rst_wr_cost", 64'(wr_cost), 64'(0));
        chk("rst_wr_bp", 64'(wr_bp), 64'(0));
        chk("rst_wr_addr", 64'(wr_addr), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_f_req", 64'(f_req), 64'(0));
        rst_in = 1'b0;
        tick();
        em[0] = 5; em[1] = 9; em[2] = 2; em[3] = 7;
        run(3, 0, 0, 32'd5, 0, "k0");
        mem[0] = 10; mem[1] = 1; mem[2] = 4;
        em[0] = 0; em[1] = 3; em[2] = 1; em[3] = 2;
        run(3, 1, 0, 32'd2, 2, "k1");
        mem[0] = 3; mem[1] = 3;
        em[0] = 0; em[1] = 4; em[2] = 4;
        run(2, 1, 0, 32'd7, 1, "tie");
        mem[0] = 32'hFFFF_FFF0;
        em[0] = 0; em[1] = 32'h20;
        run(1, 1, 0, 32'hFFFF_FFFF, 0, "sat");
        mem[0] = 100;
        em[0] = 0; em[1] = 32'hFFFF_FFFB;
        run(1, 1, 0, 32'd100, 1, "neg");
        mem[0] = 10; mem[1] = 1; mem[2] = 4;
        em[0] = 0; em[1] = 3; em[2] = 1; em[3] = 2;
        run(3, 1, 2, 32'd2, 2, "gap");
        chk("clean_err", 64'(err), 64'(0));
        tick();
        send(0, 32'd5);
        begin
            int seen = 0;
            for (int c = 0; c < 6; c++) begin
                if (wr_en) seen++;
                tick();
            end
            chk("idle_beat_nowr", 64'(seen), 64'(0));
        end
        chk("idle_beat_err", 64'(err), 64'(1));
        chk("idle_beat_busy", 64'(busy), 64'(0));
        reset_dut();
        chk("reclear_err", 64'(err), 64'(0));
        begin_pass(5, 0);
        send(0, 32'd1);
        send(1, 32'd1);
        send(2, 32'd1);
        chk("mid_busy", 64'(busy), 64'(1));
        #2 rst_in = 1'b1;
        #1;
        chk("async_busy", 64'(busy), 64'(0));
        chk("async_cost", 64'(wr_cost), 64'(0));
        chk("async_bp", 64'(wr_bp), 64'(0));
        chk("async_addr", 64'(wr_addr), 64'(0));
        @(posedge clk_in);
        #1 rst_in = 1'b0;
        tick();
        em[0] = 5; em[1] = 9; em[2] = 2; em[3] = 7;
        run(3, 0, 0, 32'd5, 0, "after_rst");
        chk("after_rst_err", 64'(err), 64'(0));
        begin_pass(2, 0);
        send(0, 32'd9);
        send(0, 32'd3);
        send(2, 32'd1);
        wait_wr("badj", 32'd3, 0, 2);
        chk("badj_err", 64'(err), 64'(1));
        reset_dut();
        begin_pass(1, 0);
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        chk("restart_err", 64'(err), 64'(1));
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
